// File: rtl/pixel_word_unpacker_pkg.sv
// Shared defaults and helpers for the pixel word unpacker.
// Geometry comes from image_defs.vh so the filter datapath and unpacker agree.
package pixel_word_unpacker_pkg;
`include "image_defs.vh"

   localparam int DEF_WORD_W = `IMG_WORD_W;
   localparam int DEF_PIX_W  = `IMG_PIX_W;
   localparam int DEF_NPIX   = `IMG_NPIX;

   // Index width, kept at least one bit wide.
   function automatic int idx_width(input int npix);
      return (npix > 2) ? $clog2(npix) : 1;
   endfunction
endpackage

// File: rtl/image_defs.vh
// Image pipeline geometry shared by the word unpacker and the image-filter datapath.
`ifndef IMAGE_DEFS_VH
`define IMAGE_DEFS_VH
`define IMG_WORD_W 32
`define IMG_PIX_W  8
`define IMG_NPIX   (`IMG_WORD_W / `IMG_PIX_W)
`endif

// File: rtl/pixel_word_unpacker_pix_sel.sv
// pix_sel: combinational NPIX:1 pixel multiplexer over one packed word.
// Lane order follows UNPACK_MSB_FIRST_EN (defined: lane 0 is the top pixel).
module pix_sel #(
   parameter int WORD_W = 32,
   parameter int PIX_W  = 8,
   parameter int NPIX   = WORD_W / PIX_W,
   parameter int IDX_W  = 2
) (
   input  logic [WORD_W-1:0] i_word,
   input  logic [IDX_W-1:0]  i_idx,
   output logic [PIX_W-1:0]  o_pix
);

   logic [PIX_W-1:0] w_lane [NPIX];

   generate
      for (genvar gi = 0; gi < NPIX; gi++) begin : g_lane
`ifdef UNPACK_MSB_FIRST_EN
         assign w_lane[gi] = i_word[WORD_W-1-gi*PIX_W -: PIX_W];
`else
         assign w_lane[gi] = i_word[gi*PIX_W +: PIX_W];
`endif
      end
   endgenerate

   // Compare-based select stays well defined when NPIX is not a power of two.
   always_comb begin
      o_pix = '0;
      for (int k = 0; k < NPIX; k++) begin
         if (i_idx == IDX_W'(k)) begin
            o_pix = w_lane[k];
         end
      end
   end

endmodule

// File: rtl/pixel_word_unpacker.sv
// Splits packed memory words into a pixel stream: one current word plus a one-word prefetch buffer.
// Build option: define UNPACK_MSB_FIRST_EN to emit the most-significant pixel of each word first.
module pixel_word_unpacker
   import pixel_word_unpacker_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int PIX_W  = DEF_PIX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_word,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [PIX_W-1:0]  out_pix,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   localparam int NPIX  = WORD_W / PIX_W;
   localparam int IDX_W = idx_width(NPIX);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

   logic [WORD_W-1:0] r_cur;
   logic [WORD_W-1:0] r_buf;
   logic              r_cur_v;
   logic              r_buf_v;
   logic [IDX_W-1:0]  r_idx;

   logic [WORD_W-1:0] w_cur_next;
   logic [WORD_W-1:0] w_buf_next;
   logic              w_cur_v_next;
   logic              w_buf_v_next;
   logic [IDX_W-1:0]  w_idx_next;

   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_last;
   logic [PIX_W-1:0]  w_pix;

   assign w_in_xfer  = in_valid && !r_buf_v;
   assign w_out_xfer = r_cur_v && out_ready;
   assign w_last     = (r_idx == LAST_IDX);

   assign in_ready  = !r_buf_v;
   assign out_valid = r_cur_v;
   assign out_last  = r_cur_v && w_last;
   assign out_pix   = w_pix;

   pix_sel #(
      .WORD_W (WORD_W),
      .PIX_W  (PIX_W),
      .NPIX   (NPIX),
      .IDX_W  (IDX_W)
   ) u_pix_sel (
      .i_word (r_cur),
      .i_idx  (r_idx),
      .o_pix  (w_pix)
   );

   always_comb begin
      w_cur_next   = r_cur;
      w_buf_next   = r_buf;
      w_cur_v_next = r_cur_v;
      w_buf_v_next = r_buf_v;
      w_idx_next   = r_idx;

      if (w_out_xfer) begin
         if (!w_last) begin
            w_idx_next = r_idx + 1'b1;
         end else begin
            w_idx_next = '0;
            // Refill priority: prefetched word, then same-cycle bypass, else go empty.
            if (r_buf_v) begin
               w_cur_next   = r_buf;
               w_buf_v_next = 1'b0;
            end else if (w_in_xfer) begin
               w_cur_next = in_word;
            end else begin
               w_cur_v_next = 1'b0;
            end
         end
      end

      if (w_in_xfer) begin
         if (!r_cur_v) begin
            w_cur_next   = in_word;
            w_cur_v_next = 1'b1;
         end else if (!(w_out_xfer && w_last)) begin
            w_buf_next   = in_word;
            w_buf_v_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur   <= '0;
         r_buf   <= '0;
         r_cur_v <= 1'b0;
         r_buf_v <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_cur   <= w_cur_next;
         r_buf   <= w_buf_next;
         r_cur_v <= w_cur_v_next;
         r_buf_v <= w_buf_v_next;
         r_idx   <= w_idx_next;
      end
   end

endmodule

// File: tb/tb_pixel_word_unpacker.sv
// Self-checking bench for pixel_word_unpacker: directed scenarios plus randomized handshakes
// against a pixel-queue reference model. Honours UNPACK_MSB_FIRST_EN when defined.
module tb_pixel_word_unpacker;

   localparam int WORD_W = 32;
   localparam int PIX_W  = 8;
   localparam int NPIX   = WORD_W / PIX_W;

   logic              clk;
   logic              rst;
   logic [WORD_W-1:0] in_word;
   logic              in_valid;
   logic              in_ready;
   logic [PIX_W-1:0]  out_pix;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   pixel_word_unpacker #(
      .WORD_W (WORD_W),
      .PIX_W  (PIX_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_word   (in_word),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_pix   (out_pix),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int pix_cnt  = 0;
   bit chk_en   = 0;

   logic [PIX_W-1:0] model_q [$];   // pixels still owed by the DUT, in emission order
   logic [PIX_W-1:0] out_log [$];   // every pixel the DUT delivered
   int               out_cycs [$];  // cycle of each delivered pixel

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Pixel k of a word in emission order, from plain shift arithmetic.
   function automatic logic [PIX_W-1:0] pix_of(input logic [WORD_W-1:0] w, input int k);
      logic [WORD_W-1:0] s;
`ifdef UNPACK_MSB_FIRST_EN
      s = w >> (PIX_W * (NPIX - 1 - k));
`else
      s = w >> (PIX_W * k);
`endif
      return s[PIX_W-1:0];
   endfunction

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic step(input logic v, input logic [WORD_W-1:0] w, input logic rdy,
                       input logic r, output logic acc);
      logic inx;
      logic outx;
      int   n;
      in_valid  = v;
      in_word   = w;
      out_ready = rdy;
      rst       = r;
      n = model_q.size();
      if (chk_en) begin
         check("out_valid", 32'(out_valid), 32'(n != 0));
         check("in_ready", 32'(in_ready), 32'(n <= NPIX));
         if (n != 0) begin
            check("out_pix", 32'(out_pix), 32'(model_q[0]));
            check("out_last", 32'(out_last), 32'(((n - 1) % NPIX) == 0));
         end else begin
            check("out_last_idle", 32'(out_last), 32'(0));
         end
      end
      inx  = v && (n <= NPIX) && !r;
      outx = rdy && (n != 0) && !r;
      if (r) begin
         model_q.delete();
      end else begin
         if (outx) begin
            out_log.push_back(model_q.pop_front());
            out_cycs.push_back(cyc);
            pix_cnt++;
         end
         if (inx) begin
            for (int k = 0; k < NPIX; k++) model_q.push_back(pix_of(w, k));
         end
      end
      acc = inx;
      cyc++;
      @(negedge clk);
      if (r) chk_en = 1;
   endtask

   task automatic drain(input int bound);
      logic acc;
      int   t;
      t = 0;
      while (model_q.size() != 0 && t < bound) begin
         step(1'b0, '0, 1'b1, 1'b0, acc);
         t++;
      end
      if (model_q.size() != 0) check("drain_timeout", 32'(model_q.size()), 32'(0));
   endtask

   initial begin
      logic acc;
      int   base;
      int   words;
      int   t;
      logic [WORD_W-1:0] stream_w [3];
      logic [PIX_W-1:0]  exp_single [4];

      rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
      @(negedge clk);
      step(1'b0, '0, 1'b0, 1'b1, acc);
      step(1'b0, '0, 1'b0, 1'b1, acc);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_last", 32'(out_last), 32'(0));
      check("rst_out_pix", 32'(out_pix), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));

      // Single word held one cycle.
`ifdef UNPACK_MSB_FIRST_EN
      exp_single = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
`else
      exp_single = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
`endif
      base = pix_cnt;
      step(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, acc);
      check("single_accept", 32'(acc), 32'(1));
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
      check("single_count", 32'(pix_cnt - base), 32'(4));
      for (int k = 0; k < 4; k++) check("single_pix", 32'(out_log[base + k]), 32'(exp_single[k]));
      check("single_span", 32'(out_cycs[base + 3] - out_cycs[base]), 32'(3));

      // Streaming with in_valid held: 12 pixels in 12 consecutive cycles.
      stream_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
      base = pix_cnt;
      for (int j = 0; j < 3; j++) begin
         t = 0;
         do begin
            step(1'b1, stream_w[j], 1'b1, 1'b0, acc);
            t++;
         end while (!acc && t < 20);
         if (!acc) check("stream_accept_timeout", 32'(j), 32'(99));
      end
      drain(40);
      check("stream_count", 32'(pix_cnt - base), 32'(12));
      if (pix_cnt - base >= 12)
         check("stream_span", 32'(out_cycs[base + 11] - out_cycs[base]), 32'(11));

      // Backpressure at idx 2; second word accepted, then in_ready must stay low.
      step(1'b1, 32'h13121110, 1'b1, 1'b0, acc);
      step(1'b0, '0, 1'b1, 1'b0, acc);
      step(1'b0, '0, 1'b1, 1'b0, acc);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'h17161514, 1'b0, 1'b0, acc);
`ifdef UNPACK_MSB_FIRST_EN
         check("bp_frozen_pix", 32'(out_pix), 32'(8'h11));
`else
         check("bp_frozen_pix", 32'(out_pix), 32'(8'h12));
`endif
         if (i > 0) check("bp_in_ready_low", 32'(in_ready), 32'(0));
      end
      drain(40);

      // Reset after two pixels of a word.
      step(1'b1, 32'h44332211, 1'b1, 1'b0, acc);
      step(1'b0, '0, 1'b1, 1'b0, acc);
      step(1'b0, '0, 1'b1, 1'b0, acc);
      step(1'b0, '0, 1'b1, 1'b1, acc);
      check("rstmid_out_valid", 32'(out_valid), 32'(0));
      check("rstmid_in_ready", 32'(in_ready), 32'(1));
      step(1'b1, 32'h88776655, 1'b1, 1'b0, acc);
`ifdef UNPACK_MSB_FIRST_EN
      check("rstmid_first_pix", 32'(out_pix), 32'(8'h88));
`else
      check("rstmid_first_pix", 32'(out_pix), 32'(8'h55));
`endif
      drain(40);

      // Randomized handshakes over 1000 accepted words.
      words = 0;
      t = 0;
      while (words < 1000 && t < 20000) begin
         step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) != 0), 1'b0, acc);
         if (acc) words++;
         t++;
      end
      check("rand_words", 32'(words), 32'(1000));
      drain(40);
      check("final_out_valid", 32'(out_valid), 32'(0));
      check("final_in_ready", 32'(in_ready), 32'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_word_unpacker.md
PIXEL_WORD_UNPACKER -- requirements
Module: pixel_word_unpacker

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning the packed input word width in bits.
REQ-002 SHALL have parameter PIX_W, default 8, meaning the output pixel width; WORD_W/PIX_W (NPIX, default 4) is an integer ≥ 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_word, input, WORD_W bits: packed pixel word from memory.
REQ-006 SHALL have port in_valid, input, 1 bit: in_word is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_word this cycle.
REQ-008 SHALL have port out_pix, output, PIX_W bits: current pixel.
REQ-009 SHALL have port out_valid, output, 1 bit: out_pix is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts out_pix.
REQ-011 SHALL have port out_last, output, 1 bit: out_pix is the final pixel of its word.

Function
REQ-012 SHALL transfer a word on in_valid&&in_ready and a pixel on out_valid&&out_ready; no other condition transfers.
REQ-013 SHALL hold a current-word register (cur, cur_v), a pixel index idx (0..NPIX-1) and a one-word prefetch buffer (buf, buf_v).
REQ-014 SHALL drive in_ready = !buf_v, a combinational function of state only, independent of in_valid.
REQ-015 SHALL drive out_valid = cur_v, out_last = cur_v && (idx == NPIX-1), and out_pix = pixel idx of cur, all registered-state only.
REQ-016 SHALL use the byte order LSB-first by default: index 0 is in_word[PIX_W-1:0].
REQ-017 SHALL, on an output transfer with idx < NPIX-1, increment idx by 1.
REQ-018 SHALL, on an output transfer with idx == NPIX-1, set idx to 0 and refill cur in priority order: from buf (clear buf_v), else from an input accepted that cycle (bypass), else clear cur_v.
REQ-019 SHALL, on an input transfer when cur_v=0, load cur directly, with a first-pixel latency of 1 cycle.
REQ-020 SHALL, on an input transfer when cur_v=1 and cur is not being refilled from it, write buf and set buf_v.
REQ-021 SHALL sustain one pixel per cycle indefinitely while in_valid and out_ready are held high.
REQ-022 SHALL hold out_pix, out_last and idx stable while out_valid=1 and out_ready=0.
REQ-023 SHALL accept simultaneous input and output transfers in the same cycle with no word loss or duplication.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, clear cur_v, buf_v and idx, discarding any partial word.
REQ-025 SHALL drive out_valid=0, out_last=0, out_pix=0 and in_ready=1 on the cycle after reset.
REQ-026 SHALL give rst priority over every simultaneous transfer.

Configuration
REQ-027 SHALL support macro UNPACK_MSB_FIRST_EN: when defined, index 0 is in_word[WORD_W-1:WORD_W-PIX_W]; when undefined, the LSB-first order of REQ-016 applies, with all timing identical.

Structure
REQ-028 SHALL take WORD_W, PIX_W and NPIX defaults from the shared header image_defs.vh, which is also used by the image-filter datapath.
REQ-029 SHALL instantiate one sub-module, pix_sel: a combinational NPIX:1 pixel multiplexer indexed by idx and honouring UNPACK_MSB_FIRST_EN.

Verification
REQ-030 SHALL cover single word: in_word=32'hDDCCBBAA held one cycle, out_ready=1 -> out_pix AA,BB,CC,DD on consecutive cycles, out_last only with DD, then out_valid=0.
REQ-031 SHALL cover streaming: words 32'h03020100, 32'h07060504, 32'h0B0A0908 back-to-back, out_ready=1 -> 12 pixels 00..0B in 12 consecutive cycles with no bubble.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles at idx=2 -> out_pix frozen; a second word is accepted, then in_ready=0 until the buffer drains.
REQ-033 SHALL cover reset mid-word: rst after 2 pixels of 32'h44332211 -> next cycle out_valid=0 and in_ready=1, and a new word 32'h88776655 emits 55 first.
REQ-034 SHALL cover the macro: with UNPACK_MSB_FIRST_EN defined, 32'hDDCCBBAA -> DD,CC,BB,AA with out_last on AA.
REQ-035 SHALL cover randomized in_valid/out_ready over 1000 words against a scoreboard -> zero mismatches, and in_ready never high while buf_v=1.
